// File: rtl/branch_resolution_queue_pkg.sv
// Shared types and counter encodings for the branch resolution queue.
package branch_resolution_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  outcome;
        logic        hit;
    } bp_entry_t;

    localparam logic [1:0] BP_STRONG_NT = 2'b00;
    localparam logic [1:0] BP_WEAK_NT   = 2'b01;
    localparam logic [1:0] BP_WEAK_T    = 2'b10;
    localparam logic [1:0] BP_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_resolution_queue_if.sv
// IF-side capture and MEM-side resolve/flush signals of the branch resolution queue.
interface branch_resolution_queue_if;
    logic        if_push;
    logic [31:0] if_pc;
    logic [31:0] if_predicted_target;
    logic [1:0]  if_predicted_outcome;
    logic        if_btb_hit;
    logic        mem_resolve;
    logic [31:0] mem_pc;
    logic        mem_is_branch;
    logic        mem_taken;
    logic [31:0] mem_target;
    logic        if_full;
    logic        mem_head_valid;
    logic [31:0] mem_predicted_pcmux_out;
    logic [1:0]  mem_predicted_branch_outcome;
    logic        mem_BTB_hit;
    logic [1:0]  mem_updated_prediction;
    logic        mem_misprediction;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        order_error;

    modport master (
        output if_push, if_pc, if_predicted_target, if_predicted_outcome, if_btb_hit,
               mem_resolve, mem_pc, mem_is_branch, mem_taken, mem_target,
        input  if_full, mem_head_valid, mem_predicted_pcmux_out, mem_predicted_branch_outcome,
               mem_BTB_hit, mem_updated_prediction, mem_misprediction, flush, redirect_pc,
               order_error
    );

    modport slave (
        input  if_push, if_pc, if_predicted_target, if_predicted_outcome, if_btb_hit,
               mem_resolve, mem_pc, mem_is_branch, mem_taken, mem_target,
        output if_full, mem_head_valid, mem_predicted_pcmux_out, mem_predicted_branch_outcome,
               mem_BTB_hit, mem_updated_prediction, mem_misprediction, flush, redirect_pc,
               order_error
    );
endinterface

// File: rtl/branch_resolution_queue_bp_counter_update.sv
// Next 2-bit predictor counter from the resolved outcome; BTB misses seed a weak state.
module bp_counter_update
    import branch_resolution_queue_pkg::*;
(
    input  logic [1:0] counter,
    input  logic       hit,
    input  logic       is_branch,
    input  logic       taken,
    output logic [1:0] next_counter
);

    always_comb begin
        next_counter = counter;
        if (is_branch) begin
            if (!hit)
                next_counter = taken ? BP_WEAK_T : BP_WEAK_NT;
            else if (taken)
                next_counter = (counter == BP_STRONG_T) ? counter : counter + 2'd1;
            else
                next_counter = (counter == BP_STRONG_NT) ? counter : counter - 2'd1;
        end
    end

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of IF-stage predictions replayed at MEM; detects mispredicts, issues flush/redirect.
// Optional perf counters are built when BRANCH_PERF_EN is defined.
module branch_resolution_queue
    import branch_resolution_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    branch_resolution_queue_if.slave bq
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    bp_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    bp_entry_t        head;
    logic             head_valid, pop, push_ok, mispred;
    logic [1:0]       next_counter;

    assign head_valid = (count != '0);
    assign head       = entries[rd_ptr];
    assign pop        = bq.mem_resolve && head_valid;
    assign push_ok    = bq.if_push && (!bq.if_full || bq.mem_resolve);

    bp_counter_update u_ctr (
        .counter      (head.outcome),
        .hit          (head.hit),
        .is_branch    (bq.mem_is_branch),
        .taken        (bq.mem_taken),
        .next_counter (next_counter)
    );

    always_comb begin
        mispred = 1'b0;
        if (pop) begin
            if (head.hit)
                mispred = (head.outcome[1] != bq.mem_taken) ||
                          (bq.mem_taken && (head.target != bq.mem_target));
            else
                mispred = bq.mem_is_branch && bq.mem_taken;
        end
    end

    // Head view reads zero when empty so stale storage never leaks to MEM.
    assign bq.if_full                      = (count == CNT_FULL);
    assign bq.mem_head_valid               = head_valid;
    assign bq.mem_predicted_pcmux_out      = head_valid ? head.target  : '0;
    assign bq.mem_predicted_branch_outcome = head_valid ? head.outcome : '0;
    assign bq.mem_BTB_hit                  = head_valid && head.hit;
    assign bq.mem_updated_prediction       = head_valid ? next_counter : '0;
    assign bq.mem_misprediction            = mispred;

    // Storage has no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push_ok && !mispred)
            entries[wr_ptr] <= '{pc: bq.if_pc, target: bq.if_predicted_target,
                                 outcome: bq.if_predicted_outcome, hit: bq.if_btb_hit};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bq.flush       <= 1'b0;
            bq.redirect_pc <= '0;
            bq.order_error <= 1'b0;
        end else begin
            bq.flush <= mispred;
            if (pop && (head.pc != bq.mem_pc))
                bq.order_error <= 1'b1;
            if (mispred) begin
                // Everything younger than the mispredicted branch is wrong-path.
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                count          <= '0;
                bq.redirect_pc <= bq.mem_taken ? bq.mem_target : bq.mem_pc + 32'd4;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (pop && bq.mem_is_branch && (perf_branches != '1))
                perf_branches <= perf_branches + 32'd1;
            if (mispred && (perf_mispredicts != '1))
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed test of branch_resolution_queue (DEPTH=4) with hand-computed expectations.
module tb_branch_resolution_queue;
    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    branch_resolution_queue_if bq ();
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    branch_resolution_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bq  (bq)
`ifdef BRANCH_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bq.if_push = 0; bq.if_pc = '0; bq.if_predicted_target = '0;
        bq.if_predicted_outcome = '0; bq.if_btb_hit = 0;
        bq.mem_resolve = 0; bq.mem_pc = '0; bq.mem_is_branch = 0;
        bq.mem_taken = 0; bq.mem_target = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] outc,
                        input logic hit);
        bq.if_push = 1; bq.if_pc = pc; bq.if_predicted_target = tgt;
        bq.if_predicted_outcome = outc; bq.if_btb_hit = hit;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt);
        bq.mem_resolve = 1; bq.mem_pc = pc; bq.mem_is_branch = br;
        bq.mem_taken = tk; bq.mem_target = tgt;
    endtask

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        chk("rst_full",   32'(bq.if_full), 0);
        chk("rst_valid",  32'(bq.mem_head_valid), 0);
        chk("rst_flush",  32'(bq.flush), 0);
        chk("rst_redir",  bq.redirect_pc, 0);
        chk("rst_order",  32'(bq.order_error), 0);
        chk("rst_target", bq.mem_predicted_pcmux_out, 0);
        rst = 1;

        // correct taken prediction
        push(32'h100, 32'h200, 2'b11, 1); tick();
        chk("t1_valid",  32'(bq.mem_head_valid), 1);
        chk("t1_target", bq.mem_predicted_pcmux_out, 32'h200);
        chk("t1_outc",   32'(bq.mem_predicted_branch_outcome), 3);
        chk("t1_hit",    32'(bq.mem_BTB_hit), 1);
        resolve(32'h100, 1, 1, 32'h200); #1;
        chk("t1_upd",    32'(bq.mem_updated_prediction), 3);
        chk("t1_misp",   32'(bq.mem_misprediction), 0);
        tick();
        chk("t1_flush",  32'(bq.flush), 0);
        chk("t1_empty",  32'(bq.mem_head_valid), 0);

        // weak-taken predicted, actually not taken; same-cycle push is dropped
        push(32'h104, 32'h180, 2'b10, 1); tick();
        resolve(32'h104, 1, 0, 32'h180);
        push(32'h999, 32'h0, 2'b00, 0); #1;
        chk("t2_upd",    32'(bq.mem_updated_prediction), 1);
        chk("t2_misp",   32'(bq.mem_misprediction), 1);
        tick();
        chk("t2_flush",  32'(bq.flush), 1);
        chk("t2_redir",  bq.redirect_pc, 32'h108);
        chk("t2_empty",  32'(bq.mem_head_valid), 0);
        tick();
        chk("t2_flush1", 32'(bq.flush), 0);
        chk("t2_redir1", bq.redirect_pc, 32'h108);

        // BTB miss on a taken jal
        push(32'h300, 32'h0, 2'b00, 0); tick();
        resolve(32'h300, 1, 1, 32'h400); #1;
        chk("t3_upd",    32'(bq.mem_updated_prediction), 2);
        chk("t3_misp",   32'(bq.mem_misprediction), 1);
        tick();
        chk("t3_flush",  32'(bq.flush), 1);
        chk("t3_redir",  bq.redirect_pc, 32'h400);
        chk("t3_empty",  32'(bq.mem_head_valid), 0);

        // fill, dropped push while full, push+pop while full, drain in order
        for (int i = 0; i < 4; i++) begin
            push(32'h10 + 32'(4*i), 32'h110 + 32'(4*i), 2'b11, 1); tick();
        end
        chk("t4_full",   32'(bq.if_full), 1);
        chk("t4_head",   bq.mem_predicted_pcmux_out, 32'h110);
        push(32'h77, 32'h777, 2'b00, 1); tick();
        chk("t4_full2",  32'(bq.if_full), 1);
        chk("t4_head2",  bq.mem_predicted_pcmux_out, 32'h110);
        push(32'h20, 32'h120, 2'b11, 1);
        resolve(32'h10, 1, 1, 32'h110); #1;
        chk("t4_misp",   32'(bq.mem_misprediction), 0);
        tick();
        chk("t4_full3",  32'(bq.if_full), 1);
        chk("t4_head3",  bq.mem_predicted_pcmux_out, 32'h114);
        for (int j = 1; j <= 4; j++) begin
            resolve(32'h10 + 32'(4*j), 1, 1, 32'h110 + 32'(4*j)); tick();
            if (j < 4) begin
                chk("t4_drain", bq.mem_predicted_pcmux_out, 32'h110 + 32'(4*(j+1)));
                chk("t4_nfull", 32'(bq.if_full), 0);
            end
        end
        chk("t4_empty",  32'(bq.mem_head_valid), 0);
        chk("t4_order",  32'(bq.order_error), 0);
        chk("t4_flush",  32'(bq.flush), 0);

        // counter saturation/passthrough, then out-of-order resolve
        push(32'h504, 32'h600, 2'b11, 1); tick();
        bq.mem_is_branch = 1; bq.mem_taken = 1; #1;
        chk("t5_sat",    32'(bq.mem_updated_prediction), 3);
        bq.mem_taken = 0; #1;
        chk("t5_dec",    32'(bq.mem_updated_prediction), 2);
        chk("t5_noresolve", 32'(bq.mem_misprediction), 0);
        bq.mem_is_branch = 0; #1;
        chk("t5_pass",   32'(bq.mem_updated_prediction), 3);
        resolve(32'h500, 1, 1, 32'h600); #1;
        chk("t5_misp",   32'(bq.mem_misprediction), 0);
        tick();
        chk("t5_order",  32'(bq.order_error), 1);
        chk("t5_flush",  32'(bq.flush), 0);
        chk("t5_empty",  32'(bq.mem_head_valid), 0);

        // resolve on empty queue
        resolve(32'h700, 1, 1, 32'h800); #1;
        chk("e_target",  bq.mem_predicted_pcmux_out, 0);
        chk("e_upd",     32'(bq.mem_updated_prediction), 0);
        chk("e_hit",     32'(bq.mem_BTB_hit), 0);
        chk("e_misp",    32'(bq.mem_misprediction), 0);
        tick();
        chk("e_flush",   32'(bq.flush), 0);
        chk("e_order",   32'(bq.order_error), 1);
        chk("e_valid",   32'(bq.mem_head_valid), 0);
`ifdef BRANCH_PERF_EN
        chk("perf_br",   perf_branches, 9);
        chk("perf_mp",   perf_mispredicts, 2);
`endif

        // reset on the mispredict edge cancels the flush
        push(32'h800, 32'h900, 2'b10, 1); tick();
        resolve(32'h800, 1, 0, 32'h900);
        rst = 0;
        tick();
        chk("r_flush",   32'(bq.flush), 0);
        chk("r_order",   32'(bq.order_error), 0);
        chk("r_redir",   bq.redirect_pc, 0);
        chk("r_valid",   32'(bq.mem_head_valid), 0);
`ifdef BRANCH_PERF_EN
        chk("r_perf_br", perf_branches, 0);
        chk("r_perf_mp", perf_mispredicts, 0);
`endif
        rst = 1;
        tick();
        chk("r_flush2",  32'(bq.flush), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/branch_resolution_queue.md
Name: branch_resolution_queue

Overview:
- Queue of in-flight branch predictions. Captures each IF-stage lookup result (BTB hit, predicted target, 2-bit counter) and replays it to MEM in program order.
- At MEM it computes the next 2-bit counter value, detects mispredictions and issues a registered flush/redirect.
- Feeds the BTB/predictor arrays' MEM-side update ports and the pipeline flush logic.

Parameters:
- DEPTH, 4, number of in-flight prediction entries (power of two, ≥2)
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- if_push  in  1  IF fetched an instruction this cycle (not stalled)
- if_pc  in  32  PC of fetched instruction
- if_predicted_target  in  32  BTB target read at IF
- if_predicted_outcome  in  2  counter read at IF
- if_btb_hit  in  1  BTB tag match at IF
- mem_resolve  in  1  oldest instruction leaves MEM this cycle
- mem_pc  in  32  PC of MEM instruction
- mem_is_branch  in  1  branch/jal/jalr in MEM
- mem_taken  in  1  actual outcome (jal/jalr = 1)
- mem_target  in  32  actual aligned target
- if_full  out  1  queue full; IF must stall
- mem_head_valid  out  1  queue non-empty
- mem_predicted_pcmux_out  out  32  head predicted target
- mem_predicted_branch_outcome  out  2  head counter
- mem_BTB_hit  out  1  head BTB hit
- mem_updated_prediction  out  2  counter value to write back
- mem_misprediction  out  1  combinational misprediction for current resolve
- flush  out  1  registered pipeline flush
- redirect_pc  out  32  registered correct fetch PC
- order_error  out  1  sticky: head PC ≠ mem_pc at resolve

Behaviour:
- Circular buffer with wr_ptr/rd_ptr PTR_W bits plus count (0..DEPTH). Entry = {pc, target, outcome, hit}.
- Push: writes at wr_ptr when if_push && (!if_full || mem_resolve). A push while full without a resolve is dropped; IF honours if_full.
- Pop: on mem_resolve && mem_head_valid. A resolve while empty is ignored and all MEM outputs read 0.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Head outputs are combinational from the entry at rd_ptr.
- Counter update, saturating:
  - Taken: 00→01→10→11→11. Not taken: 11→10→01→00→00.
  - No BTB hit and a branch: 10 if taken, 01 if not taken.
  - Not a branch: counter passes through unchanged.
- mem_misprediction (only when mem_resolve && mem_head_valid):
  - Hit: outcome[1] ≠ mem_taken, or (mem_taken && target ≠ mem_target).
  - Miss: mem_is_branch && mem_taken.
- Flush and redirect:
  - Cycle after a misprediction: flush=1 for exactly one cycle.
  - redirect_pc = mem_target if taken, else mem_pc+4 (32-bit wrap).
  - In the same cycle the misprediction is seen, the whole queue is cleared (count=0, rd_ptr=wr_ptr=0) and any same-cycle push is discarded.
- order_error sets on a resolve with head pc ≠ mem_pc; cleared only by reset.
- Reset (rst=0 at clk edge):
  - count, pointers, flush, order_error = 0; redirect_pc = 0.
  - if_full=0, mem_head_valid=0.
  - Entry storage is not cleared.
  - Reset mid-flush cancels the pending flush.
- No ready/valid beyond the above; latency IF→MEM visibility is 1 cycle after push.

Optional Feature:
- BRANCH_PERF_EN
- Defined: adds outputs perf_branches[31:0] and perf_mispredicts[31:0]. Each increments on a resolve with mem_is_branch / mem_misprediction, saturates at 0xFFFF_FFFF and resets to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- rv32i_types gains:
  - bp_entry_t struct {pc, target, outcome[1:0], hit}
  - localparams for counter encodings: BP_STRONG_NT=2'b00, BP_WEAK_NT=2'b01, BP_WEAK_T=2'b10, BP_STRONG_T=2'b11
- Sub-module bp_counter_update (pure combinational): counter, hit, is_branch, taken → next counter.

Test Plan:
- Push pc=0x100 (hit, outcome=11, target=0x200); resolve mem_pc=0x100, taken, target=0x200 → updated=11, mispred=0, no flush.
- Push pc=0x104 (hit, 10); resolve not taken → updated=01, mispred=1. Next cycle flush=1, redirect_pc=0x108, queue empty; same-cycle push dropped.
- Push pc=0x300 (miss); resolve jal taken target=0x400 → updated=10, mispred=1, redirect_pc=0x400.
- Push 4 entries (DEPTH=4) → if_full=1. Push+resolve in the same cycle → count stays 4 and the new entry is later replayed at the tail.
- Resolve with mem_pc=0x500 while head pc=0x504 → order_error=1 until rst=0. Resolve on an empty queue → no state change.
- BRANCH_PERF_EN: 3 branch resolves including 1 misprediction → perf_branches=3, perf_mispredicts=1; reset → 0.
